// File: rtl/decision_voter.sv
// decision_voter: locks onto a classifier decision once THRESH consecutive
// matching strobes have been seen, and holds it until another code (or a run
// of NONE_CODE) reaches THRESH.
// Optional feature: define DECISION_TIMEOUT_EN to drop the lock after
// TIMEOUT_CYC idle cycles. When it is not defined, TIMEOUT_CYC is not used.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   decision_valid one-cycle strobe qualifying decision
//   decision       classifier code (CODE_W bits)
//   final_answer   locked code, registered
//   final_valid    high while a non-NONE code is locked, registered
//   answer_change  one-cycle pulse when final_answer changes, registered
//   streak         current consecutive-match count (debug), registered
module decision_voter #(
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned NONE_CODE   = 0,
  parameter int unsigned THRESH      = 15,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              decision_valid,
  input  logic [CODE_W-1:0] decision,
  output logic [CODE_W-1:0] final_answer,
  output logic              final_valid,
  output logic              answer_change,
  output logic [$clog2(THRESH+1)-1:0] streak
);

  localparam int unsigned CNT_W = $clog2(THRESH + 1);
  localparam int unsigned IDLE_W = 24;
  localparam logic [CODE_W-1:0] NONE_C   = CODE_W'(NONE_CODE);
  localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESH);

  // Elaboration-time parameter range check.
  if (THRESH < 1 || THRESH > 65535 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 24'hFFFFFF) begin : g_param_chk
    $error("decision_voter: THRESH or TIMEOUT_CYC out of range");
  end

  typedef enum logic {EMPTY = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] final_answer_q, final_answer_d;
  logic              final_valid_q, final_valid_d;
  logic              answer_change_q, answer_change_d;
  logic              lock_en;
  logic [CODE_W-1:0] lock_code;
`ifdef DECISION_TIMEOUT_EN
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT_CYC);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= EMPTY;
      cand_q          <= NONE_C;
      cnt_q           <= '0;
      final_answer_q  <= NONE_C;
      final_valid_q   <= 1'b0;
      answer_change_q <= 1'b0;
`ifdef DECISION_TIMEOUT_EN
      idle_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      cnt_q           <= cnt_d;
      final_answer_q  <= final_answer_d;
      final_valid_q   <= final_valid_d;
      answer_change_q <= answer_change_d;
`ifdef DECISION_TIMEOUT_EN
      idle_q          <= idle_d;
`endif
    end
  end

  // Streak tracking, lock decision and next-state logic.
  always_comb begin
    state_d         = state_q;
    cand_d          = cand_q;
    cnt_d           = cnt_q;
    final_answer_d  = final_answer_q;
    final_valid_d   = final_valid_q;
    answer_change_d = 1'b0;
    lock_en         = 1'b0;
    lock_code       = cand_q;
`ifdef DECISION_TIMEOUT_EN
    idle_d          = idle_q;
`endif

    if (decision_valid) begin
`ifdef DECISION_TIMEOUT_EN
      idle_d = '0;
`endif
      if (decision == cand_q) begin
        // Saturate at THRESH; only the edge reaching THRESH locks.
        if (cnt_q < THRESH_C) begin
          cnt_d   = cnt_q + CNT_W'(1);
          lock_en = ((cnt_q + CNT_W'(1)) == THRESH_C);
        end
      end else begin
        cand_d    = decision;
        cnt_d     = CNT_W'(1);
        lock_en   = (THRESH == 1);
        lock_code = decision;
      end
    end

`ifdef DECISION_TIMEOUT_EN
    // Idle counter saturates at TIMEOUT_CYC so the drop fires only once.
    if (!decision_valid && (idle_q != TIMEOUT_C)) begin
      idle_d = idle_q + IDLE_W'(1);
      if ((idle_q + IDLE_W'(1)) == TIMEOUT_C) begin
        cand_d          = NONE_C;
        cnt_d           = '0;
        final_answer_d  = NONE_C;
        final_valid_d   = 1'b0;
        state_d         = EMPTY;
        answer_change_d = (final_answer_q != NONE_C);
      end
    end
`endif

    if (lock_en) begin
      final_answer_d  = lock_code;
      final_valid_d   = (lock_code != NONE_C);
      state_d         = (lock_code != NONE_C) ? LOCKED : EMPTY;
      answer_change_d = (lock_code != final_answer_q);
    end
  end

  assign final_answer  = final_answer_q;
  assign final_valid   = final_valid_q;
  assign answer_change = answer_change_q;
  assign streak        = cnt_q;

endmodule
